// File: rtl/spi_register_controller_pkg.sv
// Shared types and constants for the SPI register controller.
// Holds the frame length, the register-number type and the FSM state encoding.
package spi_register_controller_pkg;

    localparam int SPI_FRAME_BITS = 24;

    typedef logic [15:0] RegisterNumber_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } SpiCtrlState_t;

endpackage

// File: rtl/spi_input_synchronizer.sv
// Brings SCLK, CS_n and MOSI into the i_Clock domain and detects SCLK/CS_n edges.
// Edges are suppressed until the pipeline has refilled after reset.
module spi_input_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_Clock,
    input  logic i_Reset_n,
    input  logic i_SpiSclk,
    input  logic i_SpiCs_n,
    input  logic i_SpiMosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_n,
    output logic cs_fall,
    output logic cs_rise,
    output logic mosi
);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_dly_q;
    logic                   cs_dly_q;
    logic [SYNC_STAGES:0]   valid_q;
    logic                   armed;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            cs_dly_q    <= 1'b1;
            valid_q     <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_SpiSclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_SpiCs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_SpiMosi};
            sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
            cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
            valid_q     <= {valid_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // A CS_n held low across reset release must not look like a fresh frame start.
    assign armed     = valid_q[SYNC_STAGES];
    assign sclk_rise = armed &  sclk_sync_q[SYNC_STAGES-1] & ~sclk_dly_q;
    assign sclk_fall = armed & ~sclk_sync_q[SYNC_STAGES-1] &  sclk_dly_q;
    assign cs_fall   = armed & ~cs_sync_q[SYNC_STAGES-1]   &  cs_dly_q;
    assign cs_rise   = armed &  cs_sync_q[SYNC_STAGES-1]   & ~cs_dly_q;
    assign cs_n      = cs_sync_q[SYNC_STAGES-1];
    assign mosi      = mosi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_register_controller.sv
// SPI mode-0 slave that turns 24-bit frames into synth register writes and
// returns the most recent synth sample on MISO.
//
// state     | meaning
// ST_IDLE   | waiting for a CS_n falling edge
// ST_SHIFT  | receiving bits, counting SCLK rising edges
// ST_COMMIT | issuing the register write for a complete frame
module spi_register_controller
    import spi_register_controller_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset_n,
    input  logic                  i_SpiSclk,
    input  logic                  i_SpiCs_n,
    input  logic                  i_SpiMosi,
    output logic                  o_SpiMiso,
    input  logic signed [15:0]    i_Sample,
    input  logic                  i_SampleReady,
    output logic                  o_RegisterWriteEnable,
    output logic [15:0]           o_RegisterWriteNumber,
    output logic [7:0]            o_RegisterWriteValue,
    output logic                  o_FrameError
);

    logic sclk_rise, sclk_fall, cs_n, cs_fall, cs_rise, mosi;

    spi_input_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .i_SpiSclk (i_SpiSclk),
        .i_SpiCs_n (i_SpiCs_n),
        .i_SpiMosi (i_SpiMosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_n      (cs_n),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise),
        .mosi      (mosi)
    );

    SpiCtrlState_t               state_q, state_d;
    logic [4:0]                  cnt_q, cnt_d;
    logic [SPI_FRAME_BITS-1:0]   rx_q, rx_d;
    logic [SPI_FRAME_BITS-1:0]   miso_q, miso_d;
    logic [15:0]                 hold_q, hold_d;
    logic                        we_q, we_d;
    RegisterNumber_t             num_q, num_d;
    logic [7:0]                  val_q, val_d;
    logic                        ferr_q, ferr_d;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rx_q    <= '0;
            miso_q  <= '0;
            hold_q  <= '0;
            we_q    <= 1'b0;
            num_q   <= '0;
            val_q   <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            miso_q  <= miso_d;
            hold_q  <= hold_d;
            we_q    <= we_d;
            num_q   <= num_d;
            val_q   <= val_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        miso_d  = miso_q;
        hold_d  = i_SampleReady ? i_Sample : hold_q;
        we_d    = 1'b0;
        num_d   = num_q;
        val_d   = val_q;
        ferr_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    miso_d  = {hold_q, 8'h00};
                end
            end
            ST_SHIFT: begin
                if (cnt_q == 5'(SPI_FRAME_BITS)) begin
                    state_d = ST_COMMIT;
                end else if (cs_rise) begin
                    state_d = ST_IDLE;
                    ferr_d  = (cnt_q != '0);
                end else begin
                    if (sclk_rise) begin
                        rx_d  = {rx_q[SPI_FRAME_BITS-2:0], mosi};
                        cnt_d = cnt_q + 5'd1;
                    end
                    // The trailing fall of the previous frame must not eat the new MSB.
                    if (sclk_fall && cnt_q != '0) begin
                        miso_d = {miso_q[SPI_FRAME_BITS-2:0], 1'b0};
                    end
                end
            end
            ST_COMMIT: begin
                we_d  = 1'b1;
                num_d = rx_q[23:8];
                val_d = rx_q[7:0];
                cnt_d = '0;
                if (!cs_n) begin
                    state_d = ST_SHIFT;
                    miso_d  = {hold_q, 8'h00};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_SpiMiso             = miso_q[SPI_FRAME_BITS-1];
    assign o_RegisterWriteEnable = we_q;
    assign o_RegisterWriteNumber = num_q;
    assign o_RegisterWriteValue  = val_q;
    assign o_FrameError          = ferr_q;

endmodule
